// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-arbiter bus: two requester write channels, clear control and
// the registered memory write port. Modports: master (requesters/host), slave (arbiter).
interface fb_write_arbiter_if #(
   parameter int unsigned SIZE  = 307200,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned AW = $clog2(SIZE);

   logic             req0_valid;
   logic [AW-1:0]    req0_addr;
   logic [WIDTH-1:0] req0_data;
   logic             req0_ready;

   logic             req1_valid;
   logic [AW-1:0]    req1_addr;
   logic [WIDTH-1:0] req1_data;
   logic             req1_ready;

   logic             clear_start;
   logic [WIDTH-1:0] clear_value;
   logic             busy;
   logic             clear_done;

   logic             mem_write_enable;
   logic [AW-1:0]    mem_write_addr;
   logic [WIDTH-1:0] mem_data_in;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output clear_start, clear_value,
      input  req0_ready, req1_ready, busy, clear_done,
      input  mem_write_enable, mem_write_addr, mem_data_in
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  clear_start, clear_value,
      output req0_ready, req1_ready, busy, clear_done,
      output mem_write_enable, mem_write_addr, mem_data_in
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for two framebuffer writers with a registered memory write port.
// Optional full-framebuffer clear engine compiled in with FB_ARB_CLEAR_EN.
module fb_write_arbiter #(
   parameter int unsigned SIZE  = 307200,
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   fb_write_arbiter_if.slave bus
);
   localparam int unsigned AW = $clog2(SIZE);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t state;
   logic   last_grant;   // 1: req1 won the most recent transfer
   logic   grant0_c;
   logic   grant1_c;
   logic   block_c;
   logic   xfer0_c;
   logic   xfer1_c;

   // Lone requester wins; on contention the one not granted last wins.
   always_comb begin
      grant0_c = bus.req0_valid & (~bus.req1_valid | last_grant);
      grant1_c = bus.req1_valid & (~bus.req0_valid | ~last_grant);
   end

`ifdef FB_ARB_CLEAR_EN
   logic [AW-1:0] cnt;

   assign block_c  = (state != IDLE) | bus.clear_start;
   assign bus.busy = (state == CLEAR);
`else
   logic unused_c;

   assign block_c        = 1'b0;
   assign bus.busy       = 1'b0;
   assign bus.clear_done = 1'b0;
   assign unused_c       = ^{bus.clear_start, bus.clear_value};
`endif

   assign bus.req0_ready = grant0_c & ~block_c;
   assign bus.req1_ready = grant1_c & ~block_c;
   assign xfer0_c        = bus.req0_valid & bus.req0_ready;
   assign xfer1_c        = bus.req1_valid & bus.req1_ready;

   // State, grant pointer and registered memory write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         last_grant           <= 1'b1;
         bus.mem_write_enable <= 1'b0;
         bus.mem_write_addr   <= '0;
         bus.mem_data_in      <= '0;
`ifdef FB_ARB_CLEAR_EN
         cnt                  <= '0;
         bus.clear_done       <= 1'b0;
`endif
      end else begin
         bus.mem_write_enable <= 1'b0;
`ifdef FB_ARB_CLEAR_EN
         bus.clear_done       <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef FB_ARB_CLEAR_EN
               if (bus.clear_start) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
`endif
               if (xfer0_c) begin
                  bus.mem_write_enable <= 1'b1;
                  bus.mem_write_addr   <= bus.req0_addr;
                  bus.mem_data_in      <= bus.req0_data;
                  last_grant           <= 1'b0;
               end else if (xfer1_c) begin
                  bus.mem_write_enable <= 1'b1;
                  bus.mem_write_addr   <= bus.req1_addr;
                  bus.mem_data_in      <= bus.req1_data;
                  last_grant           <= 1'b1;
               end
            end
            CLEAR: begin
`ifdef FB_ARB_CLEAR_EN
               bus.mem_write_enable <= 1'b1;
               bus.mem_write_addr   <= cnt;
               bus.mem_data_in      <= bus.clear_value;
               if (cnt == AW'(SIZE - 1)) begin
                  state          <= IDLE;
                  cnt            <= '0;
                  bus.clear_done <= 1'b1;
               end else begin
                  cnt <= cnt + AW'(1);
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter SIZE SHALL be 307200 and is the number of framebuffer words; legal values are 2 and above.
REQ-002 Parameter WIDTH SHALL be 8 and is the pixel word width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Ports req0_valid/req1_valid  input  1  SHALL flag a pending write from host (0) or draw engine (1).
REQ-006 Ports req0_addr/req1_addr  input  $clog2(SIZE)  SHALL carry each requester's write address.
REQ-007 Ports req0_data/req1_data  input  WIDTH  SHALL carry each requester's write data.
REQ-008 Ports req0_ready/req1_ready  output  1  SHALL signal acceptance; a transfer occurs when valid and ready are both high.
REQ-009 Port clear_start  input  1  SHALL request a full-framebuffer fill with clear_value.
REQ-010 Port clear_value  input  WIDTH  SHALL be the fill pixel, sampled every clear cycle.
REQ-011 Ports mem_write_enable (1), mem_write_addr ($clog2(SIZE)), mem_data_in (WIDTH)  output  SHALL drive the framebuffer memory write port.
REQ-012 Port busy  output  1  SHALL be high while a clear is in progress.
REQ-013 Port clear_done  output  1  SHALL pulse high for one cycle when a clear completes.

Function
REQ-014 The FSM SHALL have the states IDLE and CLEAR.
REQ-015 In IDLE, the grant SHALL be computed combinationally: a lone valid requester is granted; when both are valid, the requester not granted last is granted.
REQ-016 readyN SHALL equal grantN AND state==IDLE AND NOT clear_start; at most one ready SHALL be high per cycle.
REQ-017 The last-grant pointer SHALL update only on a completed transfer; after reset it SHALL favour req0.
REQ-018 A transfer in cycle N SHALL produce mem_write_enable=1 with that address and data in cycle N+1, because the memory outputs are registered (1-cycle latency).
REQ-019 With no transfer and no clear write, mem_write_enable SHALL be 0 the next cycle, and mem_write_addr and mem_data_in SHALL hold their previous values.
REQ-020 clear_start in IDLE SHALL move the FSM to CLEAR at the next edge, with the address counter at 0.
REQ-021 clear_start has priority over requester transfers presented in the same cycle: both readies are low in that cycle.
REQ-022 In CLEAR, the block SHALL issue one write per cycle (addr = counter, data = clear_value) and increment the counter.
REQ-023 Writing address SIZE-1 SHALL end the clear: return to IDLE, reset the counter to 0, and pulse clear_done in the cycle after the last write is presented.
REQ-024 In CLEAR, both readies SHALL be 0 and clear_start SHALL be ignored; requesters hold valid with stable addr and data until accepted.
REQ-025 busy SHALL be high exactly while state==CLEAR.

Reset
REQ-026 While rst is high, the following SHALL hold immediately and independently of clk:
- state=IDLE, counter=0, pointer favours req0;
- mem_write_enable=0, mem_write_addr=0, mem_data_in=0;
- busy=0, clear_done=0.
REQ-027 Reset during CLEAR SHALL abort the fill with no clear_done pulse; already-written words are not restored.

Configuration
REQ-028 The macro FB_ARB_CLEAR_EN SHALL compile in the clear engine.
REQ-029 With FB_ARB_CLEAR_EN defined, REQ-020..REQ-025 SHALL apply.
REQ-030 With FB_ARB_CLEAR_EN undefined:
- clear_start and clear_value are ignored;
- busy and clear_done are tied to 0;
- readies depend only on grant.

Verification (SIZE=16, WIDTH=8)
REQ-031 Lone write: req0 valid with addr=5, data=0xA3 -> req0_ready=1 the same cycle; next cycle mem_write_enable=1, addr=5, data=0xA3.
REQ-032 Contention: both requesters valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants alternate 0,1,0,1 and four writes issue on consecutive cycles.
REQ-033 Clear: clear_start with clear_value=0x00 -> busy for 16 cycles; writes to addresses 0..15 with data 0x00; one clear_done pulse; busy=0 afterwards.
REQ-034 Collision: req1 valid in the same cycle as clear_start -> req1_ready=0 throughout the clear; req1 is accepted in the first IDLE cycle after the clear, with its write issued the cycle after.
REQ-035 Reset mid-clear: rst asserted at counter=7 -> busy=0 and mem_write_enable=0 immediately, no clear_done, and the next clear restarts at address 0.
REQ-036 Build without FB_ARB_CLEAR_EN: clear_start pulsed -> busy stays 0 and no clear writes occur; scenario REQ-031 still passes.
